serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, inputs, WIDTH bits each, the unsigned or two's-complement operands; sampled on an accepted start.
REQ-006 The block SHALL have port cin, input, 1 bit, the carry-in; sampled on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking sum/cout valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits, the result of a+b+cin modulo 2^WIDTH.
REQ-010 The block SHALL have port cout, output, 1 bit, the carry out of bit WIDTH-1.

Function
REQ-011 The datapath SHALL be one 1-bit full-adder cell, one carry flip-flop, two operand right-shift registers, one sum shift register and a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 SHALL load a, b into the shift registers, load cin into the carry flop, clear the counter and sum register, and move to SHIFT.
REQ-014 IDLE with start=0 SHALL hold all registers.
REQ-015 Each SHIFT cycle SHALL add the operand LSBs with the carry flop, shift the sum bit into sum MSB (sum register shifts right), shift both operands right by one, store the cell carry-out in the carry flop and increment the counter.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, then move to DONE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-020 With start high at edge N, done SHALL be high during cycle N+WIDTH+1, and a new start is accepted from edge N+WIDTH+2 onward.
REQ-021 sum and cout SHALL be valid from the done cycle and held unchanged until the next accepted start.
REQ-022 cout SHALL equal the carry flop contents after the last SHIFT cycle.
REQ-023 Operand inputs SHALL be don't-care outside the accepting edge, and changes during SHIFT SHALL NOT affect the result.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and clear the counter, carry, and operand and sum registers; busy=0, done=0, sum=0, cout=0 (and ovf=0 when present).
REQ-025 rst SHALL take priority over start and SHALL abort an addition in progress; no done pulse follows.
REQ-026 The first edge with rst=0 and start=1 SHALL be accepted normally.

Configuration
REQ-027 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf, 1 bit, the two's-complement overflow flag, equal to the carry into the MSB XOR the carry out of the MSB, captured during the final SHIFT cycle and held like sum.
REQ-028 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent, with all other behaviour identical.

Verification (WIDTH=8)
REQ-029 The bench SHALL check a=0x0F, b=0x01, cin=0 -> done at cycle 9 after start, sum=0x10, cout=0.
REQ-030 The bench SHALL check a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 The bench SHALL check a second start pulse and changed a/b 3 cycles into SHIFT -> ignored; the original result is delivered and done pulses exactly once.
REQ-032 The bench SHALL check rst asserted 4 cycles into SHIFT -> next cycle busy=0, sum=0, cout=0, and no done pulse; a new start then yields a correct result.
REQ-033 The bench SHALL check, with SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; and a=0x80, b=0xFF -> sum=0x7F, ovf=1, cout=1.
REQ-034 The bench SHALL check that after done and with no new start, sum and cout hold for at least 10 cycles and busy stays 0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes a+b+cin LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output 'ovf'.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   opA_q, opA_d;
   logic [WIDTH-1:0]   opB_q, opB_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic               sumBit;
   logic               cellCarry;
   logic               lastShift;

   assign sumBit    = opA_q[0] ^ opB_q[0] ^ carry_q;
   assign cellCarry = (opA_q[0] & opB_q[0]) | (carry_q & (opA_q[0] ^ opB_q[0]));
   assign lastShift = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               opA_d   = a;
               opB_d   = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            opA_d   = {1'b0, opA_q[WIDTH-1:1]};
            opB_d   = {1'b0, opB_q[WIDTH-1:1]};
            sum_d   = {sumBit, sum_q[WIDTH-1:1]};
            carry_d = cellCarry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (lastShift) begin
`ifdef SERIAL_ADDER_OVF_EN
               // On the MSB cycle carry_q is the carry into the MSB.
               ovf_d   = carry_q ^ cellCarry;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Overflow checks are active when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`else
   logic       ovfExpLast;
`endif

   int checkCount = 0;
   int errorCount = 0;
   int doneCount  = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   // 10 ns clock; outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count every done pulse so duplicate or missing pulses are visible.
   always @(negedge clk) begin
      if (done) doneCount++;
   end

   // Hard stop in case a wait somewhere never resolves.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents operands with start for exactly one rising edge, then scrambles the operand inputs.
   task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn, input logic cinIn);
      @(negedge clk);
      rst   = 1'b0;
      a     = aIn;
      b     = bIn;
      cin   = cinIn;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
   endtask

   // Runs one addition; injectCyc>0 re-pulses start with new operands in that cycle.
   task automatic runAdd(input string tag, input logic [7:0] aIn, input logic [7:0] bIn,
                         input logic cinIn, input logic [7:0] expSum, input logic expCout,
                         input logic expOvf, input int injectCyc);
      int cyc;
      int doneBefore;
      doneBefore = doneCount;
      applyStimulus(aIn, bIn, cinIn);
      cyc = 1;
      @(negedge clk);
      while (!done && cyc < 20) begin
         if (cyc == injectCyc) begin
            start = 1'b1;
            a     = 8'hAA;
            b     = 8'hCC;
            cin   = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checkOutput({tag, ".latency"}, 32'(cyc), 32'd9);
      checkOutput({tag, ".done"}, 32'(done), 32'd1);
      checkOutput({tag, ".busyInDone"}, 32'(busy), 32'd1);
      checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
      checkOutput({tag, ".cout"}, 32'(cout), 32'(expCout));
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
`else
      ovfExpLast = expOvf;
`endif
      @(negedge clk);
      checkOutput({tag, ".doneAfter"}, 32'(done), 32'd0);
      checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
      checkOutput({tag, ".sumHeld"}, 32'(sum), 32'(expSum));
      checkOutput({tag, ".donePulses"}, 32'(doneCount - doneBefore), 32'd1);
   endtask

   initial begin
      int snap;
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h5A;
      b     = 8'hA5;
      cin   = 1'b1;

      // Reset state, with start held low.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.sum", 32'(sum), 32'd0);
      checkOutput("reset.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("reset.ovf", 32'(ovf), 32'd0);
`endif

      // First edge out of reset carries start.
      runAdd("add0F_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
      runAdd("addFF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      runAdd("addFF_FF_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);

      // Start and operands changed three shifts in must be ignored.
      snap = doneCount;
      runAdd("ignoreStart", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 4);
      repeat (12) @(negedge clk);
      checkOutput("ignoreStart.noExtraDone", 32'(doneCount - snap), 32'd1);
      checkOutput("ignoreStart.idle", 32'(busy), 32'd0);

      // Reset after four shift cycles aborts the addition.
      snap = doneCount;
      applyStimulus(8'h55, 8'h0A, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort.busy", 32'(busy), 32'd0);
      checkOutput("abort.done", 32'(done), 32'd0);
      checkOutput("abort.sum", 32'(sum), 32'd0);
      checkOutput("abort.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("abort.ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("abort.noDone", 32'(doneCount - snap), 32'd0);
      runAdd("afterAbort", 8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0, 0);

      // Result must hold with no new start.
      runAdd("hold", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a = 8'($urandom);
         b = 8'($urandom);
         checkOutput("hold.sum", 32'(sum), 32'h2C);
         checkOutput("hold.cout", 32'(cout), 32'd1);
         checkOutput("hold.busy", 32'(busy), 32'd0);
         checkOutput("hold.done", 32'(done), 32'd0);
      end

      // Signed overflow cases.
      runAdd("ovf7F_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
      runAdd("ovf80_FF", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
